stream_mux: RTL

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/stream_mux_if.sv | 28 ++
 rtl/stream_mux.sv | 97 +++++++++
 2 files changed

// File: rtl/stream_mux_if.sv
// Handshake bundle for stream_mux: N valid/ready input channels feeding one
// registered output, plus the completed-transfer counter.
interface stream_mux_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int S = (N > 1) ? $clog2(N) : 1;

    logic [S-1:0]   io_sel;
    logic [N-1:0]   io_in_valid;
    logic [N*W-1:0] io_in_bits;
    logic [N-1:0]   io_in_ready;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [W-1:0]   io_out_bits;
    logic [S-1:0]   io_out_chan;
    logic [15:0]    io_count;

    modport slave (
        input  io_sel, io_in_valid, io_in_bits, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_out_chan, io_count
    );

    modport master (
        output io_sel, io_in_valid, io_in_bits, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_out_chan, io_count
    );
endinterface

// File: rtl/stream_mux.sv
// N-to-1 stream multiplexer with a single output register: external select
// (MODE 0) or round-robin arbitration (MODE 1), full throughput.
module stream_mux #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input logic         clock,
    input logic         reset,
    stream_mux_if.slave io
);
    localparam int S = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NU = N;

    logic         load_en;
    logic         grant_vld;
    logic [S-1:0] grant;
    logic [W-1:0] grant_bits;
    logic         xfer_in;
    logic         xfer_out;

    logic         out_valid;
    logic [W-1:0] out_bits;
    logic [S-1:0] out_chan;
    logic [S-1:0] ptr;
    logic [15:0]  count;

    assign load_en = !out_valid || io.io_out_ready;

    // Round-robin picks the valid channel with the smallest distance from ptr,
    // which equals the first hit of a wrap-around scan starting at ptr.
    always_comb begin : arbiter
        int unsigned best_d;
        int unsigned d;
        grant_vld = 1'b0;
        grant     = '0;
        best_d    = NU;
        d         = 0;
        if (MODE == 0) begin
            if (32'(io.io_sel) < NU) begin
                grant_vld = 1'b1;
                grant     = io.io_sel;
            end
        end else begin
            for (int unsigned i = 0; i < NU; i++) begin
                d = (i + NU - 32'(ptr)) % NU;
                if (io.io_in_valid[i] && d < best_d) begin
                    best_d    = d;
                    grant     = S'(i);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_bits = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (grant == S'(i)) grant_bits = io.io_in_bits[i*W +: W];
        end
    end

    always_comb begin
        io.io_in_ready = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            io.io_in_ready[i] = !reset && grant_vld && load_en && (grant == S'(i));
        end
    end

    assign xfer_in  = !reset && grant_vld && load_en && io.io_in_valid[grant];
    assign xfer_out = out_valid && io.io_out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_bits  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
            count     <= '0;
        end else begin
            if (xfer_in) begin
                out_valid <= 1'b1;
                out_bits  <= grant_bits;
                out_chan  <= grant;
            end else if (xfer_out) begin
                out_valid <= 1'b0;
            end
            if (xfer_out) count <= count + 16'd1;
            if (MODE == 1 && xfer_in) ptr <= (grant == S'(N - 1)) ? '0 : grant + 1'b1;
        end
    end

    assign io.io_out_valid = out_valid;
    assign io.io_out_bits  = out_bits;
    assign io.io_out_chan  = out_chan;
    assign io.io_count     = count;
endmodule
